// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, sync bundle and
// frame-buffer address helpers shared by the scan-out slice.
package vga_pkg;

   localparam logic [9:0] H_ACTIVE     = 10'd640;
   localparam logic [9:0] H_FP         = 10'd16;
   localparam logic [9:0] H_SYNC       = 10'd96;
   localparam logic [9:0] H_BP         = 10'd48;
   localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
   localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;

   localparam logic [9:0] V_ACTIVE     = 10'd480;
   localparam logic [9:0] V_FP         = 10'd10;
   localparam logic [9:0] V_SYNC       = 10'd2;
   localparam logic [9:0] V_BP         = 10'd33;
   localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
   localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

   // Row start address; multiply by COLS as two shifts and an add.
   function automatic logic [19:0] row_base(input logic [19:0] r,
                                            input int cols);
      logic [19:0] b;
      unique case (1'b1)
         cols == 640: b = (r << 9) + (r << 7);
         cols == 320: b = (r << 8) + (r << 6);
         default:     b = (r << 7) + (r << 5);
      endcase
      return b;
   endfunction

   function automatic int rep_shift(input int cols);
      int s;
      unique case (1'b1)
         cols == 640: s = 0;
         cols == 320: s = 1;
         default:     s = 2;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-enable toggle, h/v counters, sync/active decode
// (one pixel stage deep) and the end-of-frame pulse.
module vga_sync_gen
   import vga_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       Resetn,
   output logic       pix_en,
   output logic [9:0] hc,
   output logic [9:0] vc,
   output sync_t      sync,
   output logic       frame_done
);

   logic  toggle;
   logic  h_end;
   logic  v_end;
   sync_t sync_raw;

   assign pix_en     = toggle;
   assign h_end      = (hc == H_LAST);
   assign v_end      = (vc == V_LAST);
   assign frame_done = toggle & h_end & v_end;

   always_comb begin
      sync_raw        = SYNC_IDLE;
      sync_raw.hs     = ~((hc >= H_SYNC_START) && (hc < H_SYNC_END));
      sync_raw.vs     = ~((vc >= V_SYNC_START) && (vc < V_SYNC_END));
      sync_raw.active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         toggle <= 1'b0;
         hc     <= '0;
         vc     <= '0;
         sync   <= SYNC_IDLE;
      end else begin
         toggle <= ~toggle;
         if (toggle) begin
            hc   <= h_end ? '0 : hc + 10'd1;
            sync <= sync_raw;
            if (h_end)
               vc <= v_end ? '0 : vc + 10'd1;
         end
      end
   end

endmodule

// File: rtl/vga_frame_scanout.sv
// 12-bit frame buffer with a free-running write port and a
// replicated-pixel VGA scan-out, two pixel clocks of latency.
module vga_frame_scanout
   import vga_pkg::*;
#(
   parameter int nX   = 8,
   parameter int nY   = nX - 1,
   parameter int COLS = 160,
   parameter int ROWS = 120,
   parameter int Mn   = 15
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   input  logic [nX-1:0] VGA_X,
   input  logic [nY-1:0] VGA_Y,
   input  logic [23:0]   VGA_COLOR,
   input  logic          plot,
   output logic [7:0]    VGA_R,
   output logic [7:0]    VGA_G,
   output logic [7:0]    VGA_B,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_BLANK_N,
   output logic          VGA_SYNC_N,
   output logic          VGA_CLK,
   output logic          frame_done
);

   localparam int S = rep_shift(COLS);

   logic          pix_en;
   logic [9:0]    hc;
   logic [9:0]    vc;
   sync_t         sync;
   logic [11:0]   mem [2**Mn];
   logic [11:0]   rd_data;
   logic [11:0]   wr_data;
   logic [Mn-1:0] wr_addr;
   logic [Mn-1:0] rd_addr;
   logic          wr_ok;
   logic          unused_color;

   vga_sync_gen u_sync (
      .CLOCK_50   (CLOCK_50),
      .Resetn     (Resetn),
      .pix_en     (pix_en),
      .hc         (hc),
      .vc         (vc),
      .sync       (sync),
      .frame_done (frame_done)
   );

   assign VGA_CLK    = pix_en;
   assign VGA_SYNC_N = 1'b0;

   assign wr_data = {VGA_COLOR[23:20], VGA_COLOR[15:12], VGA_COLOR[7:4]};
   assign unused_color = ^{VGA_COLOR[19:16], VGA_COLOR[11:8],
                           VGA_COLOR[3:0]};

   assign wr_ok = plot && (32'(VGA_X) < COLS) && (32'(VGA_Y) < ROWS);

   assign wr_addr = Mn'(row_base(20'(VGA_Y), COLS) + 20'(VGA_X));
   assign rd_addr = Mn'(row_base(20'(vc >> S), COLS) + 20'(hc >> S));

   // Read-before-write: a same-address collision returns the old pixel.
   always_ff @(posedge CLOCK_50) begin
      if (wr_ok)
         mem[wr_addr] <= wr_data;
      if (pix_en)
         rd_data <= mem[rd_addr];
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= 8'h00;
         VGA_G       <= 8'h00;
         VGA_B       <= 8'h00;
      end else if (pix_en) begin
         VGA_HS      <= sync.hs;
         VGA_VS      <= sync.vs;
         VGA_BLANK_N <= sync.active;
         VGA_R       <= sync.active ? {2{rd_data[11:8]}} : 8'h00;
         VGA_G       <= sync.active ? {2{rd_data[7:4]}}  : 8'h00;
         VGA_B       <= sync.active ? {2{rd_data[3:0]}}  : 8'h00;
      end
   end

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout: reset vectors, restart timing and a
// two-frame scan compared against a position-based frame model.
module tb_vga_frame_scanout;

   localparam int COLS   = 160;
   localparam int ROWS   = 120;
   localparam int NX     = 8;
   localparam int NY     = 7;
   localparam int MN     = 15;
   localparam int HT     = 800;
   localparam int VT     = 525;
   localparam int FRAME  = HT * VT;
   localparam int KEND   = 4 * FRAME + 8;
   localparam int COLL_K = 2 * (20 * HT + 40) + 2;

   logic          CLOCK_50 = 1'b0;
   logic          Resetn = 1'b0;
   logic [NX-1:0] VGA_X = '0;
   logic [NY-1:0] VGA_Y = '0;
   logic [23:0]   VGA_COLOR = '0;
   logic          plot = 1'b0;
   logic [7:0]    VGA_R, VGA_G, VGA_B;
   logic          VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic          VGA_CLK, frame_done;

   int checks = 0;
   int failures = 0;

   vga_frame_scanout #(
      .nX(NX), .nY(NY), .COLS(COLS), .ROWS(ROWS), .Mn(MN)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .Resetn      (Resetn),
      .VGA_X       (VGA_X),
      .VGA_Y       (VGA_Y),
      .VGA_COLOR   (VGA_COLOR),
      .plot        (plot),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_SYNC_N  (VGA_SYNC_N),
      .VGA_CLK     (VGA_CLK),
      .frame_done  (frame_done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input longint act,
                        input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                  name, act, act, req, req);
      end
   endtask

   function automatic logic [23:0] expand(input logic [11:0] c);
      return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
   endfunction

   function automatic logic [11:0] pack12(input logic [23:0] c);
      return {c[23:20], c[15:12], c[7:4]};
   endfunction

   typedef struct {
      int   run;
      logic hs;
      logic vs;
      logic blank;
   } rst_vec_t;

   rst_vec_t    rvec[6];
   logic [11:0] fb [COLS*ROWS];
   logic [11:0] rdval [4];
   string       sname [6] = '{"hs", "vs", "blank_n", "rgb", "vga_clk",
                              "frame_done"};
   int          bad [2][6];
   int          first_bad [2][6];
   int          fd_cnt [2];
   int          blk_n [2];
   int          blk_bad [2];
   int          nb_bad [2];
   logic [23:0] coll [2];

   initial begin
      int n, p, q, h, v, rq, rh, rv, fi, wx, wy;
      int hs_fall [2];
      int vs_fall [2];
      int hs_rise, vs_rise, n_hs, n_vs;
      logic wr, e_hs, e_vs, e_bl, e_clk, e_fd, prev_hs, prev_vs;
      logic [23:0] wc, e_rgb, rgb;
      logic [5:0] mis;

      rvec[0] = '{10,   1'b1, 1'b1, 1'b1};
      rvec[1] = '{1282, 1'b1, 1'b1, 1'b1};
      rvec[2] = '{1284, 1'b1, 1'b1, 1'b0};
      rvec[3] = '{1320, 1'b0, 1'b1, 1'b0};
      rvec[4] = '{1506, 1'b0, 1'b1, 1'b0};
      rvec[5] = '{1508, 1'b1, 1'b1, 1'b0};

      // Reset vectors: run, check, then drop Resetn between edges.
      for (int i = 0; i < 6; i++) begin
         Resetn = 1'b0;
         @(posedge CLOCK_50);
         #5 Resetn = 1'b1;
         repeat (rvec[i].run) @(posedge CLOCK_50);
         #1;
         check($sformatf("pre_reset_%0d", i),
               {VGA_HS, VGA_VS, VGA_BLANK_N},
               {rvec[i].hs, rvec[i].vs, rvec[i].blank});
         #($urandom_range(1, 8)) Resetn = 1'b0;
         #1;
         check($sformatf("reset_async_%0d", i),
               {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
                VGA_CLK, frame_done}, {3'b110, 24'h0, 2'b00});
         repeat (3) @(posedge CLOCK_50);
         #1;
         check($sformatf("reset_hold_%0d", i),
               {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
                VGA_CLK, frame_done}, {3'b110, 24'h0, 2'b00});
      end
      check("sync_n_tied_low", VGA_SYNC_N, 0);

      // Mid-frame reset: first HS fall 658 pixel clocks after release.
      @(posedge CLOCK_50);
      #5 Resetn = 1'b1;
      repeat (5000) @(posedge CLOCK_50);
      #3 Resetn = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      #5 Resetn = 1'b1;
      n = 0;
      for (int i = 1; i <= 4000; i++) begin
         @(posedge CLOCK_50);
         #1;
         if (!VGA_HS) begin
            n = i;
            break;
         end
      end
      check("restart_hs_fall_clock50_edges", n, 1316);

      // Two-frame scan with directed and random writes.
      foreach (fb[i]) fb[i] = '0;
      foreach (rdval[i]) rdval[i] = '0;
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 6; s++) begin
            bad[f][s] = 0;
            first_bad[f][s] = -1;
         end
         fd_cnt[f] = 0;
         blk_n[f] = 0;
         blk_bad[f] = 0;
         nb_bad[f] = 0;
         coll[f] = 24'hx;
         hs_fall[f] = -1;
         vs_fall[f] = -1;
      end
      hs_rise = -1;
      vs_rise = -1;
      n_hs = 0;
      n_vs = 0;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
      Resetn = 1'b0;
      @(posedge CLOCK_50);
      #5 Resetn = 1'b1;

      for (int k = 1; k <= KEND; k++) begin
         wr = 1'b0;
         wx = 0;
         wy = 0;
         wc = 24'h0;
         if (k == 1) begin
            wr = 1'b1; wc = 24'h123456;
         end else if (k == 2) begin
            wr = 1'b1; wx = 160; wc = 24'hFFFFFF;
         end else if (k == 3) begin
            wr = 1'b1; wy = 120; wc = 24'hFFFFFF;
         end else if (k == COLL_K) begin
            wr = 1'b1; wx = 10; wy = 5; wc = 24'hABCDEF;
         end else if ($urandom_range(0, 31) == 0) begin
            wr = 1'b1;
            do begin
               wx = int'($urandom_range(0, 167));
               wy = int'($urandom_range(0, 123));
            end while ((wx < 2 && wy == 0) || (wx == 0 && wy == 1) ||
                       (wx == 10 && wy == 5));
            wc = 24'($urandom);
         end
         plot = wr;
         VGA_X = NX'(wx);
         VGA_Y = NY'(wy);
         VGA_COLOR = wc;

         @(posedge CLOCK_50);
         // Pixel q is fetched on pixel edge 2q+2, before that edge's write.
         if (k % 2 == 0) begin
            rq = k / 2 - 1;
            rh = rq % HT;
            rv = (rq / HT) % VT;
            if (rh < 640 && rv < 480)
               rdval[rq % 4] = fb[(rv / 4) * COLS + rh / 4];
            else
               rdval[rq % 4] = '0;
         end
         if (wr && wx < COLS && wy < ROWS)
            fb[wy * COLS + wx] = pack12(wc);
         #1;

         p = k / 2;
         e_clk = (k % 2 == 1);
         e_fd = (k % 2 == 1) && (p % FRAME == FRAME - 1);
         q = -1;
         h = 0;
         v = 0;
         e_hs = 1'b1;
         e_vs = 1'b1;
         e_bl = 1'b0;
         e_rgb = 24'h0;
         if (p >= 2) begin
            q = p - 2;
            h = q % HT;
            v = (q / HT) % VT;
            e_hs = !(h >= 656 && h < 752);
            e_vs = !(v >= 490 && v < 492);
            e_bl = (h < 640 && v < 480);
            e_rgb = e_bl ? expand(rdval[q % 4]) : 24'h0;
         end
         rgb = {VGA_R, VGA_G, VGA_B};
         fi = (p < FRAME) ? 0 : 1;
         mis = {frame_done != e_fd, VGA_CLK != e_clk, rgb != e_rgb,
                VGA_BLANK_N != e_bl, VGA_VS != e_vs, VGA_HS != e_hs};
         for (int s = 0; s < 6; s++) begin
            if (mis[s]) begin
               if (bad[fi][s] == 0)
                  first_bad[fi][s] = k;
               bad[fi][s]++;
            end
         end
         if (frame_done)
            fd_cnt[fi]++;

         if (k % 2 == 0 && q >= 0 && q < 2 * FRAME) begin
            fi = q / FRAME;
            if (h < 4 && v < 4) begin
               blk_n[fi]++;
               if (rgb != 24'h113355)
                  blk_bad[fi]++;
            end
            if (((h >= 4 && h < 8 && v < 4) ||
                 (h < 4 && v >= 4 && v < 8)) && rgb != 24'h0)
               nb_bad[fi]++;
            if (h == 40 && v == 20)
               coll[fi] = rgb;
         end

         if (prev_hs && !VGA_HS && n_hs < 2) begin
            hs_fall[n_hs] = k;
            n_hs++;
         end
         if (!prev_hs && VGA_HS && n_hs == 1 && hs_rise < 0)
            hs_rise = k;
         if (prev_vs && !VGA_VS && n_vs < 2) begin
            vs_fall[n_vs] = k;
            n_vs++;
         end
         if (!prev_vs && VGA_VS && n_vs == 1 && vs_rise < 0)
            vs_rise = k;
         prev_hs = VGA_HS;
         prev_vs = VGA_VS;
      end
      plot = 1'b0;

      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 6; s++)
            check($sformatf("frame%0d_%s_mismatches(first_edge=%0d)",
                            f, sname[s], first_bad[f][s]), bad[f][s], 0);
         check($sformatf("frame%0d_frame_done_cycles", f), fd_cnt[f], 1);
         check($sformatf("frame%0d_block00_seen", f), blk_n[f], 16);
         check($sformatf("frame%0d_block00_not_113355", f), blk_bad[f], 0);
         check($sformatf("frame%0d_neighbours_nonzero", f), nb_bad[f], 0);
      end
      check("collision_frame0_old", coll[0], 24'h000000);
      check("collision_frame1_new", coll[1], 24'hAACCEE);
      check("hs_period_vga_clks", (hs_fall[1] - hs_fall[0]) / 2, 800);
      check("hs_low_vga_clks", (hs_rise - hs_fall[0]) / 2, 96);
      check("vs_period_vga_clks", (vs_fall[1] - vs_fall[0]) / 2, 420000);
      check("vs_low_vga_clks", (vs_rise - vs_fall[0]) / 2, 1600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_frame_scanout.md
VGA_FRAME_SCANOUT -- requirements
Module: vga_frame_scanout

Interface
REQ-001 The block SHALL have parameter nX, default 8, meaning the VGA_X bit width (9 for 320x240, 10 for 640x480).
REQ-002 The block SHALL have parameter nY, default nX-1, meaning the VGA_Y bit width.
REQ-003 The block SHALL have parameters COLS, ROWS and Mn, defaults 160, 120 and 15, meaning frame-buffer columns, rows and address bits (320/240/17 and 640/480/19 are also legal).
REQ-004 The block SHALL have the port CLOCK_50  in  1  as its single 50 MHz clock.
REQ-005 The block SHALL have the port Resetn  in  1  as its asynchronous, active-low reset.
REQ-006 The block SHALL have the port VGA_X  in  nX  as the write column.
REQ-007 The block SHALL have the port VGA_Y  in  nY  as the write row.
REQ-008 The block SHALL have the port VGA_COLOR  in  24  as the write colour {R8,G8,B8}.
REQ-009 The block SHALL have the port plot  in  1  as the write strobe; a write occurs on each CLOCK_50 edge while it is high.
REQ-010 The block SHALL have the ports VGA_R, VGA_G, VGA_B  out  8 each  as the scanned-out colour.
REQ-011 The block SHALL have the ports VGA_HS, VGA_VS  out  1 each  as active-low syncs.
REQ-012 The block SHALL have the ports VGA_BLANK_N, VGA_SYNC_N  out  1 each; BLANK_N is low outside the active area, and SYNC_N is tied 0.
REQ-013 The block SHALL have the port VGA_CLK  out  1  as the 25 MHz pixel clock, equal to CLOCK_50/2.
REQ-014 The block SHALL have the port frame_done  out  1  as a one-CLOCK_50-cycle pulse at end of frame.

Function
REQ-015 Writes SHALL store {VGA_COLOR[23:20],VGA_COLOR[15:12],VGA_COLOR[7:4]} (12 bits) at address y*COLS+x, computed by shift-add (160=128+32, 320=256+64, 640=512+128).
REQ-016 Writes with x>=COLS or y>=ROWS SHALL be discarded.
REQ-017 A toggle register SHALL create a pixel enable (pix_en) every second CLOCK_50 cycle; VGA_CLK SHALL equal that toggle.
REQ-018 The horizontal counter hc SHALL count 0..799 on pix_en and wrap to 0.
REQ-019 The horizontal timing SHALL be 640 active, 16 front porch, 96 sync (hc 656..751), 48 back porch.
REQ-020 The vertical counter vc SHALL increment when hc wraps, count 0..524 and then wrap.
REQ-021 The vertical timing SHALL be 480 active, 10 front porch, 2 sync (vc 490..491), 33 back porch.
REQ-022 Read address SHALL be (vc>>S)*COLS+(hc>>S), with S=0/1/2 for COLS=640/320/160 (pixel replication).
REQ-023 Output colour SHALL expand each 4-bit channel by nibble duplication, e.g. 4'hA->8'hAA.
REQ-024 Outside the active area, RGB SHALL be 0.
REQ-025 The memory read SHALL be synchronous with 1-cycle latency.
REQ-026 HS, VS, BLANK_N and RGB SHALL be registered and delayed so all appear exactly 2 pix_en periods after the hc/vc that produced them.
REQ-027 A simultaneous write and read to the same address SHALL return old data on the read.
REQ-028 The write port SHALL never stall; plot has no back-pressure.
REQ-029 frame_done SHALL pulse on the pix_en cycle where hc=799 and vc=524.

Reset
REQ-030 While Resetn=0, outputs SHALL be held as follows, independent of the clock: hc=vc=0, toggle=0, VGA_CLK=0, HS=VS=1, BLANK_N=0, RGB=0, frame_done=0.
REQ-031 Frame-buffer contents SHALL NOT be cleared by reset; the simulation power-up value SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL restart timing at hc=vc=0 upon deassertion, and the first HS fall SHALL occur 658 pixel clocks later.

Structure
REQ-033 Timing constants (H/V active, porch and sync widths, totals) SHALL reside in package vga_pkg.
REQ-034 The counters, sync generation and frame_done SHALL form the sub-module vga_sync_gen.
REQ-035 The frame buffer SHALL be an inferred simple dual-port RAM of 2**Mn x 12 inside the top module.

Verification
REQ-036 The bench SHALL check reset: Resetn=0 at an arbitrary time -> HS=VS=1, BLANK_N=0, RGB=0 immediately.
REQ-037 The bench SHALL check line timing: a free run gives HS period 800 VGA_CLKs and HS low for 96 VGA_CLKs.
REQ-038 The bench SHALL check frame timing: VS period 420000 VGA_CLKs, VS low for 1600 VGA_CLKs, and one frame_done pulse per frame.
REQ-039 The bench SHALL check a write (160x120): plot (0,0)=24'h123456 -> the first 4x4 active block outputs R=11, G=33, B=55, and neighbouring pixels output 0.
REQ-040 The bench SHALL check range rejection: a write at x=160, y=0 with FFFFFF -> pixel (0,1) and the entire frame remain 0.
REQ-041 The bench SHALL check a same-address collision: a write to a pixel in the same cycle it is read -> the current frame shows old data and the next frame shows new data.
